// File: rtl/upload_pkg.sv
// Shared definitions for the upload packer.
// Contents: FSM state encoding, default frame header bytes and the I2C
// handler source command codes.
package upload_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_COLLECT,
    S_HDR0,
    S_HDR1,
    S_SRC,
    S_LEN_H,
    S_LEN_L,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  localparam logic [7:0] DEF_HDR0 = 8'hAA;
  localparam logic [7:0] DEF_HDR1 = 8'h44;

  localparam logic [7:0] CMD_I2C_CONFIG = 8'h04;
  localparam logic [7:0] CMD_I2C_WRITE  = 8'h05;
  localparam logic [7:0] CMD_I2C_READ   = 8'h06;

endpackage

// File: rtl/upload_frame_buf.sv
// Payload buffer for one frame: BUF_DEPTH x 8 RAM with one write port and one
// registered read port.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              return both pointers and the count to zero (frame end)
//   wr_en, wr_data   store one byte at the write pointer
//   rd_en            load rd_data from the read pointer, then advance it
//   rd_data          registered read data
//   count            bytes written since the last clear
module upload_frame_buf #(
  parameter int unsigned BUF_DEPTH = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [7:0]                       wr_data,
  input  logic                             rd_en,
  output logic [7:0]                       rd_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  logic [7:0]      mem [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [7:0]      rd_data_q;

  // Storage carries no reset; stale contents are never read because the
  // count gates every frame.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= 8'h00;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_q + 1'b1;
      end
      if (rd_en) begin
        rd_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/upload_packer.sv
// Collects a handler upload burst and emits it as one framed packet:
//   HDR0 HDR1 SRC LEN_H LEN_L PAYLOAD[N] CSUM
// CSUM is the 8-bit sum of SRC, LEN_H, LEN_L and all payload bytes.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   upload_active                  handler upload phase (high for the burst)
//   upload_req                     handler request, informational only
//   upload_data/source/valid       incoming payload byte and its source code
//   upload_ready                   packer can accept a byte this cycle
//   out_data/out_valid/out_ready   framed byte stream toward the transmitter
//   src_err                        sticky: source changed within a frame
module upload_packer
  import upload_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 256,
  parameter logic [7:0]  HDR0      = DEF_HDR0,
  parameter logic [7:0]  HDR1      = DEF_HDR1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upload_active,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       src_err
);

  localparam int unsigned     CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(BUF_DEPTH);

  state_t          state_q, state_d;
  logic [7:0]      src_q;
  logic [7:0]      csum_q;
  logic [CntW-1:0] pay_cnt_q;
  logic            src_err_q;

  logic [CntW-1:0] count;
  logic [7:0]      rd_data;
  logic [15:0]     len;
  logic            collecting;
  logic            accept;
  logic            xfer;
  logic            pay_last;
  logic            rd_en;
  logic            buf_clr;

  logic unused_upload_req;
  assign unused_upload_req = upload_req;

  upload_frame_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (buf_clr),
    .wr_en   (accept),
    .wr_data (upload_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count)
  );

  assign len        = 16'(count);
  assign collecting = (state_q == S_IDLE) || (state_q == S_COLLECT);
  // Held low during reset so the handler never sees a spurious ready.
  assign upload_ready = rst_n & collecting & (count != Full);
  assign accept       = upload_valid & upload_ready;
  assign out_valid    = !collecting;
  assign xfer         = out_valid & out_ready;
  assign pay_last     = (pay_cnt_q == (count - 1'b1));
  assign src_err      = src_err_q;

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    buf_clr = 1'b0;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        // Close on a full buffer, or when the burst ends with data held
        // (a byte accepted in that same cycle still belongs to this frame).
        if ((accept && ((count + 1'b1) == Full)) ||
            (!upload_active && (accept || (count != '0)))) begin
          state_d = S_HDR0;
        end else if (accept) begin
          state_d = S_COLLECT;
        end else if (!upload_active) begin
          state_d = S_IDLE;
        end
      end
      S_HDR0:  if (xfer) state_d = S_HDR1;
      S_HDR1:  if (xfer) state_d = S_SRC;
      S_SRC:   if (xfer) state_d = S_LEN_H;
      S_LEN_H: if (xfer) state_d = S_LEN_L;
      S_LEN_L: begin
        // Prefetch the first payload byte so PAYLOAD starts without a bubble.
        if (xfer) begin
          state_d = S_PAYLOAD;
          rd_en   = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          if (pay_last) begin
            state_d = S_CSUM;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          buf_clr = 1'b1;
          state_d = upload_active ? S_COLLECT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_data = 8'h00;
    unique case (state_q)
      S_HDR0:    out_data = HDR0;
      S_HDR1:    out_data = HDR1;
      S_SRC:     out_data = src_q;
      S_LEN_H:   out_data = len[15:8];
      S_LEN_L:   out_data = len[7:0];
      S_PAYLOAD: out_data = rd_data;
      S_CSUM:    out_data = csum_q + src_q + len[15:8] + len[7:0];
      default:   out_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= 8'h00;
      csum_q    <= 8'h00;
      pay_cnt_q <= '0;
      src_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        csum_q <= csum_q + upload_data;
        if (count == '0) begin
          src_q <= upload_source;
        end else if (upload_source != src_q) begin
          src_err_q <= 1'b1;
        end
      end
      if ((state_q == S_PAYLOAD) && xfer) begin
        pay_cnt_q <= pay_cnt_q + 1'b1;
      end
      if (buf_clr) begin
        csum_q    <= 8'h00;
        pay_cnt_q <= '0;
      end
    end
  end

endmodule
